// File: rtl/bpsk_demodulator.sv
// BPSK demodulator: correlates each symbol period against a square-wave
// approximation of the reference sine, decides one bit per symbol and
// packs WORD_BITS decisions LSB first into an output word.
module bpsk_demodulator #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_BITS  = 9
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         en,
    input  logic                         sync,
    input  logic signed [DATA_WIDTH-1:0] signal_in,
    output logic                         locked,
    output logic                         bit_out,
    output logic                         bit_valid,
    output logic [WORD_BITS-1:0]         data_out,
    output logic                         data_valid
);

    localparam int ACC_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int BCW   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    typedef enum logic {UNLOCKED, TRACK} state_t;

    state_t                   state, state_d;
    logic signed [ACC_W-1:0]  acc, acc_d;
    logic [ADDR_WIDTH-1:0]    samp_cnt, samp_cnt_d;
    logic [BCW-1:0]           bit_cnt, bit_cnt_d;
    logic [WORD_BITS-1:0]     shreg, shreg_d;
    logic                     locked_d, bit_out_d, bit_valid_d, data_valid_d;
    logic [WORD_BITS-1:0]     data_out_d;

    logic signed [ACC_W-1:0]  sig_ext;
    logic signed [ACC_W-1:0]  sum;
    logic                     decision;

    // Correlation term: reference weight is +1 in the first half-symbol, -1 in the second.
    always_comb begin
        sig_ext  = ACC_W'(signal_in);
        sum      = samp_cnt[ADDR_WIDTH-1] ? (acc - sig_ext) : (acc + sig_ext);
        decision = ~sum[ACC_W-1];
    end

    // Next-state and output logic; sync takes priority over the end-of-symbol decision.
    always_comb begin
        state_d      = state;
        acc_d        = acc;
        samp_cnt_d   = samp_cnt;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        locked_d     = locked;
        bit_out_d    = bit_out;
        data_out_d   = data_out;
        bit_valid_d  = 1'b0;
        data_valid_d = 1'b0;
        if (en) begin
            if (sync) begin
                state_d    = TRACK;
                locked_d   = 1'b1;
                acc_d      = sig_ext;
                samp_cnt_d = ADDR_WIDTH'(1);
                bit_cnt_d  = '0;
            end else if (state == TRACK) begin
                samp_cnt_d = samp_cnt + ADDR_WIDTH'(1);
                if (samp_cnt == '1) begin
                    bit_out_d        = decision;
                    bit_valid_d      = 1'b1;
                    acc_d            = '0;
                    shreg_d[bit_cnt] = decision;
                    if (bit_cnt == BCW'(WORD_BITS - 1)) begin
                        bit_cnt_d    = '0;
                        data_out_d   = {decision, shreg[WORD_BITS-2:0]};
                        data_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + BCW'(1);
                    end
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= UNLOCKED;
            acc        <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            locked     <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            samp_cnt   <= samp_cnt_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            locked     <= locked_d;
            bit_out    <= bit_out_d;
            bit_valid  <= bit_valid_d;
            data_out   <= data_out_d;
            data_valid <= data_valid_d;
        end
    end

endmodule
